tdc_capture_ctrl: RTL
=====================

Name: tdc_capture_ctrl

Overview:
Capture sequencer sitting directly upstream of the 256-address x 32-bit sample RAM (129 entries populated, addresses 0..128). After being armed, it waits for a trigger edge and then writes a burst of 32-bit delay-line snapshots into consecutive RAM addresses through the RAM's write port (wen/waddr/wdata). It raises done when the burst completes so the readout logic can drain the RAM.

Parameters:
DEPTH, 128, number of sample words per burst; legal range 1..128.
SYNC_STAGES, 2, trigger synchronizer flop count; minimum 2.

Ports:
clk  input  1  system clock; also drives the RAM wrclk.
rst  input  1  synchronous, active-high reset.
arm  input  1  one-cycle pulse; starts a capture when in IDLE or DONE.
abort  input  1  one-cycle pulse; cancels the capture and returns to IDLE.
trigger  input  1  asynchronous trigger; only a rising edge is used.
decim  input  4  sample decimation; one sample is written every decim+1 cycles.
sample  input  32  delay-line snapshot, already registered in the clk domain.
wen  output  1  RAM write enable.
waddr  output  8  RAM write address.
wdata  output  32  RAM write data.
busy  output  1  high in ARMED and CAPTURE.
done  output  1  high in DONE.
count  output  8  number of sample words written in the current or last burst.

Behaviour:
- All outputs are registered.
- Reset values: wen=0, waddr=0, wdata=0, busy=0, done=0, count=0, state=IDLE, synchronizer flops=0.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE -> ARMED on arm. Entering ARMED clears count to 0.
- ARMED -> CAPTURE on a synchronized rising edge of trigger.
  - Edge = last synchronizer stage high AND the edge-detect flop low.
  - trigger first sampled high at edge N: first wen=1 appears after edge N+SYNC_STAGES+1 (N+3 at the default).
  - A trigger that is already high on entry to ARMED does not fire. The edge-detect flop tracks trigger in all states.
- CAPTURE write timing:
  - On each write cycle: wen=1, wdata=sample sampled at that edge, waddr=base+count. count increments at the same edge.
  - base=0, or 1 when TRIG_TIMESTAMP_EN is defined.
  - Write cycles are spaced decim+1 cycles apart. The first write is on the first CAPTURE cycle.
  - decim is latched when the trigger fires; changes mid-burst are ignored.
  - wen=0 on all non-write cycles.
- CAPTURE -> DONE after the write with count reaching DEPTH. wen deasserts on the next cycle.
- DONE holds done=1 and keeps count at its final value. arm -> ARMED (done drops, count cleared).
- abort in ARMED or CAPTURE -> IDLE at the next edge. wen=0 from that edge; count keeps its partial value.
- abort has priority over trigger and over any pending write in the same cycle.
- arm while busy is ignored. arm and abort in the same cycle: abort wins.
- waddr never exceeds base+DEPTH-1 (at most 128). There is no wrap.
- rst mid-burst: wen=0 on the cycle after the reset edge; all state returns to reset values.

Optional Feature:
TRIG_TIMESTAMP_EN
- Defined:
  - A 32-bit counter clears on entry to ARMED and increments each ARMED cycle, saturating at 0xFFFFFFFF.
  - On the first CAPTURE cycle, the counter value is written to address 0 (wen=1). Samples then occupy addresses 1..DEPTH.
  - The first sample write follows decim+1 cycles later.
  - count excludes the timestamp word.
- Not defined: no counter exists; samples occupy addresses 0..DEPTH-1.

Test Plan:
- Basic burst: DEPTH=128, decim=0, arm, trigger rises 10 cycles later -> first wen at trigger+3. 128 consecutive writes to addr 0..127, each with wdata=sample. Then done=1, count=128, busy=0.
- Decimation: decim=3, DEPTH=4 -> writes 4 cycles apart at addr 0..3. Exactly 4 wen pulses, then done.
- Stuck-high trigger: trigger held high before arm -> no capture. Drop trigger and raise it again -> capture starts.
- Abort mid-burst: abort after 5 writes -> wen=0 next cycle, state IDLE, count=5, done=0. A subsequent arm+trigger restarts from addr 0.
- Reset mid-burst: rst high during CAPTURE -> all outputs 0 on the next cycle. A further trigger without arm writes nothing.
- TRIG_TIMESTAMP_EN defined: trigger edge detected 20 cycles after arm -> addr 0 holds the timestamp (20, ±sync latency and checked exactly by the bench model), then samples at addr 1..128, count=128.

Source files
------------

// File: rtl/tdc_capture_ctrl.sv
// Capture sequencer: after arm, waits for a synchronized trigger rising edge and bursts
// DEPTH decimated samples into the sample RAM. Optional macro TRIG_TIMESTAMP_EN prepends an arm-to-trigger timestamp.
module tdc_capture_ctrl #(
  parameter int DEPTH       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        abort,
  input  logic        trigger,
  input  logic [3:0]  decim,
  input  logic [31:0] sample,
  output logic        wen,
  output logic [7:0]  waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

`ifdef TRIG_TIMESTAMP_EN
  localparam logic [7:0] BASE = 8'd1;
`else
  localparam logic [7:0] BASE = 8'd0;
`endif
  localparam logic [7:0] LAST_CNT = 8'(DEPTH - 1);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_prev_q;
  logic [3:0]             decim_q;
  logic [3:0]             div_q;
  logic                   wen_q;
  logic [7:0]             waddr_q;
  logic [31:0]            wdata_q;
  logic                   busy_q;
  logic                   done_q;
  logic [7:0]             count_q;
  logic                   trig_edge_d;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0]            ts_q;
  logic                   ts_pend_q;
`endif

  // The edge flop follows the synchronized trigger in every state, so a level
  // that is already high when ARMED is entered never looks like an edge.
  assign trig_edge_d = sync_q[SYNC_STAGES-1] & ~trig_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      trig_prev_q <= 1'b0;
      decim_q     <= 4'd0;
      div_q       <= 4'd0;
      wen_q       <= 1'b0;
      waddr_q     <= 8'd0;
      wdata_q     <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 8'd0;
`ifdef TRIG_TIMESTAMP_EN
      ts_q        <= 32'd0;
      ts_pend_q   <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], trigger};
      trig_prev_q <= sync_q[SYNC_STAGES-1];
      wen_q       <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm && !abort) begin
            state_q <= S_ARMED;
            count_q <= 8'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef TRIG_TIMESTAMP_EN
            ts_q    <= 32'd0;
`endif
          end
        end
        S_ARMED: begin
`ifdef TRIG_TIMESTAMP_EN
          if (ts_q != 32'hFFFF_FFFF) ts_q <= ts_q + 32'd1;
`endif
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (trig_edge_d) begin
            state_q   <= S_CAPTURE;
            decim_q   <= decim;
            div_q     <= 4'd0;
`ifdef TRIG_TIMESTAMP_EN
            ts_pend_q <= 1'b1;
`endif
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
`ifdef TRIG_TIMESTAMP_EN
          end else if (ts_pend_q) begin
            wen_q     <= 1'b1;
            waddr_q   <= 8'd0;
            wdata_q   <= ts_q;
            ts_pend_q <= 1'b0;
            div_q     <= decim_q;
`endif
          end else if (div_q == 4'd0) begin
            wen_q   <= 1'b1;
            waddr_q <= BASE + count_q;
            wdata_q <= sample;
            count_q <= count_q + 8'd1;
            div_q   <= decim_q;
            if (count_q == LAST_CNT) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            div_q <= div_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule
